// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and parameter limits for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam int CNT_W   = 4;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    // A 4-bit counter loaded with at most 15 can never wrap.
    function automatic bit latency_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Load/decrement latency counter; 'last' flags the final wait cycle.
module mem_lat_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch (IF) and load/store (DM),
// one access at a time, DM having fixed priority over IF.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (!latency_ok(MEM_LATENCY)) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
    end

    arb_state_t state;
    owner_t     owner;
    logic       wr_pending;
    logic       dm_req;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_last;
    logic       capture;

    assign dm_req   = dm_read | dm_write;
    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // The issue cycle itself does not count down, so 'last' lands on cycle T+MEM_LATENCY.
    assign cnt_load = (state == IDLE) && (if_req || dm_req);
    assign cnt_dec  = (state == WAIT) && !mem_en;
    assign capture  = (state == WAIT) && !mem_en && cnt_last;

    mem_lat_counter u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LATENCY)),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            wr_pending <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req) begin
                        owner      <= OWN_DM;
                        wr_pending <= dm_write;
                        mem_en     <= 1'b1;
                        mem_we     <= dm_write;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        state      <= WAIT;
                    end else if (if_req) begin
                        owner      <= OWN_IF;
                        wr_pending <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_addr   <= if_addr;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (capture) begin
                        state <= DONE;
                        if (owner == OWN_DM) begin
                            dm_ack <= 1'b1;
                            if (!wr_pending) begin
                                dm_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at latencies 2 (main), 1 (throughput) and 15 (long wait).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we;

    logic        if_req1, if_ack1, if_stall1, dm_ack1, dm_stall1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

    logic        if_req15, if_ack15, if_stall15, dm_ack15, dm_stall15, mem_en15, mem_we15;
    logic [31:0] if_rdata15, dm_rdata15, mem_addr15, mem_wdata15;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(32'h0000_1000), .if_rdata(if_rdata1), .if_ack(if_ack1), .if_stall(if_stall1),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_rdata(dm_rdata1), .dm_ack(dm_ack1), .dm_stall(dm_stall1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(32'h0101_0101)
    );

    mem_port_arbiter #(.MEM_LATENCY(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req15), .if_addr(32'h0000_2000), .if_rdata(if_rdata15), .if_ack(if_ack15), .if_stall(if_stall15),
        .dm_read(1'b0), .dm_write(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_rdata(dm_rdata15), .dm_ack(dm_ack15), .dm_stall(dm_stall15),
        .mem_en(mem_en15), .mem_we(mem_we15), .mem_addr(mem_addr15), .mem_wdata(mem_wdata15),
        .mem_rdata(32'h1515_1515)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, outputs checked 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        int ackCount;
        int enCount;

        rst_n = 1'b0;
        if_req = 0; dm_read = 0; dm_write = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        if_req1 = 0; if_req15 = 0;
        tick(); tick();
        checkOutput("rst_if_rdata", if_rdata, 32'h0);
        checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
        checkOutput("rst_if_ack", {31'b0, if_ack}, 32'h0);
        checkOutput("rst_dm_ack", {31'b0, dm_ack}, 32'h0);
        checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_stalls", {30'b0, if_stall, dm_stall}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Plain fetch of 0x40; data only valid in cycle 3 so a wrong capture cycle is caught.
        if_req = 1; if_addr = 32'h40;
        #1 checkOutput("f_c0_stall", {31'b0, if_stall}, 32'h1);
        checkOutput("f_c0_mem_en", {31'b0, mem_en}, 32'h0);
        tick(); #1;
        checkOutput("f_c1_mem_en", {31'b0, mem_en}, 32'h1);
        checkOutput("f_c1_mem_addr", mem_addr, 32'h40);
        checkOutput("f_c1_mem_we", {31'b0, mem_we}, 32'h0);
        tick(); #1;
        checkOutput("f_c2_mem_en", {31'b0, mem_en}, 32'h0);
        checkOutput("f_c2_stall", {31'b0, if_stall}, 32'h1);
        tick(); mem_rdata = 32'hDEAD_BEEF; #1;
        checkOutput("f_c3_ack", {31'b0, if_ack}, 32'h0);
        checkOutput("f_c3_stall", {31'b0, if_stall}, 32'h1);
        tick(); mem_rdata = 32'h0; #1;
        checkOutput("f_c4_ack", {31'b0, if_ack}, 32'h1);
        checkOutput("f_c4_rdata", if_rdata, 32'hDEAD_BEEF);
        checkOutput("f_c4_stall", {31'b0, if_stall}, 32'h0);
        if_req = 0;
        tick(); #1;
        checkOutput("f_c5_ack", {31'b0, if_ack}, 32'h0);
        tick();

        // Simultaneous DM load and fetch: DM first, IF issues 5 cycles after DM's mem_en.
        dm_read = 1; dm_addr = 32'h200; if_req = 1; if_addr = 32'h44;
        #1 checkOutput("p_c0_stalls", {30'b0, if_stall, dm_stall}, 32'h3);
        tick(); #1;
        checkOutput("p_c1_mem_en", {31'b0, mem_en}, 32'h1);
        checkOutput("p_c1_mem_addr", mem_addr, 32'h200);
        tick(); #1;
        tick(); mem_rdata = 32'hA5A5_0001; #1;
        checkOutput("p_c3_if_stall", {31'b0, if_stall}, 32'h1);
        tick(); mem_rdata = 32'h0; #1;
        checkOutput("p_c4_dm_ack", {31'b0, dm_ack}, 32'h1);
        checkOutput("p_c4_dm_rdata", dm_rdata, 32'hA5A5_0001);
        checkOutput("p_c4_dm_stall", {31'b0, dm_stall}, 32'h0);
        checkOutput("p_c4_if_ack", {31'b0, if_ack}, 32'h0);
        checkOutput("p_c4_if_stall", {31'b0, if_stall}, 32'h1);
        dm_read = 0;
        tick(); #1;
        checkOutput("p_c5_mem_en", {31'b0, mem_en}, 32'h0);
        checkOutput("p_c5_if_stall", {31'b0, if_stall}, 32'h1);
        tick(); #1;
        checkOutput("p_c6_mem_en", {31'b0, mem_en}, 32'h1);
        checkOutput("p_c6_mem_addr", mem_addr, 32'h44);
        tick(); #1;
        tick(); mem_rdata = 32'h1111_2222; #1;
        checkOutput("p_c8_if_stall", {31'b0, if_stall}, 32'h1);
        tick(); mem_rdata = 32'h0; #1;
        checkOutput("p_c9_if_ack", {31'b0, if_ack}, 32'h1);
        checkOutput("p_c9_if_rdata", if_rdata, 32'h1111_2222);
        checkOutput("p_c9_dm_rdata", dm_rdata, 32'hA5A5_0001);
        if_req = 0;
        tick(); tick();

        // Store with dm_read also high is a write; dm_rdata must not change.
        dm_read = 1; dm_write = 1; dm_addr = 32'h100; dm_wdata = 32'h1234; mem_rdata = 32'hFFFF_FFFF;
        tick(); #1;
        checkOutput("w_c1_mem_en", {31'b0, mem_en}, 32'h1);
        checkOutput("w_c1_mem_we", {31'b0, mem_we}, 32'h1);
        checkOutput("w_c1_mem_addr", mem_addr, 32'h100);
        checkOutput("w_c1_mem_wdata", mem_wdata, 32'h1234);
        tick(); tick(); tick(); #1;
        checkOutput("w_c4_dm_ack", {31'b0, dm_ack}, 32'h1);
        checkOutput("w_c4_dm_rdata", dm_rdata, 32'hA5A5_0001);
        dm_read = 0; dm_write = 0; mem_rdata = 32'h0;
        tick(); #1;
        checkOutput("w_c5_dm_ack", {31'b0, dm_ack}, 32'h0);
        tick();

        // Reset in the issue/WAIT cycle abandons the access.
        if_req = 1; if_addr = 32'h60;
        tick(); #1;
        checkOutput("r_c1_mem_en", {31'b0, mem_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("r_async_mem_en", {31'b0, mem_en}, 32'h0);
        checkOutput("r_async_mem_addr", mem_addr, 32'h0);
        if_req = 0;
        tick();
        rst_n = 1'b1;
        ackCount = 0;
        enCount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            ackCount += int'(if_ack);
            enCount += int'(mem_en);
        end
        checkOutput("r_no_ack", 32'(ackCount), 32'h0);
        checkOutput("r_no_issue", 32'(enCount), 32'h0);
        if_req = 1; if_addr = 32'h80;
        tick(); #1;
        checkOutput("r_new_mem_en", {31'b0, mem_en}, 32'h1);
        checkOutput("r_new_mem_addr", mem_addr, 32'h80);
        tick(); tick(); mem_rdata = 32'h0BAD_F00D;
        tick(); mem_rdata = 32'h0; #1;
        checkOutput("r_new_ack", {31'b0, if_ack}, 32'h1);
        checkOutput("r_new_rdata", if_rdata, 32'h0BAD_F00D);
        if_req = 0;
        tick(); tick();

        // MEM_LATENCY=1 with a held fetch: issues at 1,5,9,13 and acks at 3,7,11.
        if_req1 = 1;
        for (int c = 0; c < 14; c++) begin
            #1;
            checkOutput($sformatf("l1_mem_en_c%0d", c), {31'b0, mem_en1}, {31'b0, (c % 4) == 1});
            checkOutput($sformatf("l1_if_ack_c%0d", c), {31'b0, if_ack1}, {31'b0, (c % 4) == 3});
            tick();
        end
        if_req1 = 0;
        tick(); tick();

        // MEM_LATENCY=15: mem_en in cycle 1, ack 16 cycles later in cycle 17.
        if_req15 = 1;
        for (int c = 0; c < 19; c++) begin
            #1;
            checkOutput($sformatf("l15_mem_en_c%0d", c), {31'b0, mem_en15}, {31'b0, c == 1});
            checkOutput($sformatf("l15_if_ack_c%0d", c), {31'b0, if_ack15}, {31'b0, c == 17});
            if (c == 17) begin
                checkOutput("l15_if_rdata", if_rdata15, 32'h1515_1515);
            end
            tick();
        end
        if_req15 = 0;
        tick();
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
